// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
// Contents:
//   state_e - arbiter FSM states (S_IDLE, S_REQ, S_RESP)
//   owner_e - which requester owns the in-flight transaction (OWN_IF, OWN_DM)
//   SZ_*    - access size encodings (byte, half, word)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_RESP = 2'b10
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the fetch and data requesters.
// Data requests normally win because they belong to the older instruction.
// Build option MEM_ARB_FAIR_EN: when defined, a fetch that has watched
// STARVE_LIMIT consecutive data wins is forced through on the next pick.
// Ports:
//   if_req, dm_req - pending requests
//   starve_cnt     - consecutive data wins while fetch was waiting
//   if_win, dm_win - one-hot (or zero) winner
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int CNT_W        = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             if_req,
  input  logic             dm_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             if_win,
  output logic             dm_win
);

  logic force_if_s;

`ifdef MEM_ARB_FAIR_EN
  assign force_if_s = if_req && (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
  // Counter is still kept by the top level; it simply has no say here.
  logic unused_starve_s;
  assign unused_starve_s = ^starve_cnt;
  assign force_if_s      = 1'b0;
`endif

  // Data wins unless fetch is being forced; fetch takes whatever is left.
  always_comb begin
    dm_win = 1'b0;
    if_win = 1'b0;
    if (dm_req && !force_if_s) begin
      dm_win = 1'b1;
    end else begin
      if_win = if_req;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported backing memory between fetch and memory stages.
// One transaction in flight: IDLE (grant) -> REQ (wait bk_ready) -> RESP
// (wait bk_rvalid) -> IDLE. Responses are routed to the owning requester.
// Build option MEM_ARB_FAIR_EN enables anti-starvation for fetch (see
// mem_arb_pick).
// Ports:
//   clock, reset                   - clock, synchronous active-high reset
//   if_req/if_addr/if_gnt          - fetch request handshake
//   if_rvalid/if_rdata             - fetch response
//   dm_req/dm_we/dm_size/dm_addr/dm_wdata/dm_gnt - data request handshake
//   dm_rvalid/dm_rdata             - data response (rdata undefined on store)
//   bk_req/bk_we/bk_size/bk_addr/bk_wdata/bk_ready - backend request
//   bk_rvalid/bk_rdata             - backend response
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              bk_req,
  output logic              bk_we,
  output logic [1:0]        bk_size,
  output logic [ADDR_W-1:0] bk_addr,
  output logic [DATA_W-1:0] bk_wdata,
  input  logic              bk_ready,
  input  logic              bk_rvalid,
  input  logic [DATA_W-1:0] bk_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  state_e              state_r;
  owner_e              owner_r;
  logic [CNT_W-1:0]    starve_cnt_r;
  logic                bk_req_r;
  logic                bk_we_r;
  logic [1:0]          bk_size_r;
  logic [ADDR_W-1:0]   bk_addr_r;
  logic [DATA_W-1:0]   bk_wdata_r;
  logic                if_win_s;
  logic                dm_win_s;

  mem_arb_pick #(
    .CNT_W        (CNT_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .starve_cnt (starve_cnt_r),
    .if_win     (if_win_s),
    .dm_win     (dm_win_s)
  );

  // Grants only exist in IDLE; the picker guarantees they are exclusive.
  assign if_gnt = !reset && (state_r == S_IDLE) && if_win_s;
  assign dm_gnt = !reset && (state_r == S_IDLE) && dm_win_s;

  assign bk_req   = bk_req_r;
  assign bk_we    = bk_we_r;
  assign bk_size  = bk_size_r;
  assign bk_addr  = bk_addr_r;
  assign bk_wdata = bk_wdata_r;

  // Transaction FSM, backend request registers, owner and starvation counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= S_IDLE;
      owner_r      <= OWN_IF;
      starve_cnt_r <= {CNT_W{1'b0}};
      bk_req_r     <= 1'b0;
      bk_we_r      <= 1'b0;
      bk_size_r    <= 2'b00;
      bk_addr_r    <= {ADDR_W{1'b0}};
      bk_wdata_r   <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (dm_gnt) begin
            owner_r    <= OWN_DM;
            bk_req_r   <= 1'b1;
            bk_we_r    <= dm_we;
            bk_size_r  <= dm_size;
            bk_addr_r  <= dm_addr;
            bk_wdata_r <= dm_wdata;
            state_r    <= S_REQ;
            // Only a data win over a waiting fetch counts as starvation.
            if (if_req && (starve_cnt_r != CNT_W'(STARVE_LIMIT))) begin
              starve_cnt_r <= starve_cnt_r + CNT_W'(1);
            end
          end else if (if_gnt) begin
            owner_r      <= OWN_IF;
            bk_req_r     <= 1'b1;
            bk_we_r      <= 1'b0;
            bk_size_r    <= SZ_W;
            bk_addr_r    <= if_addr;
            bk_wdata_r   <= {DATA_W{1'b0}};
            state_r      <= S_REQ;
            starve_cnt_r <= {CNT_W{1'b0}};
          end
        end
        S_REQ: begin
          if (bk_ready) begin
            bk_req_r <= 1'b0;
            state_r  <= S_RESP;
          end
        end
        S_RESP: begin
          if (bk_rvalid) begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r  <= S_IDLE;
          bk_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Route the backend response to the owner only; the other side sees zeros.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = {DATA_W{1'b0}};
    dm_rvalid = 1'b0;
    dm_rdata  = {DATA_W{1'b0}};
    if (!reset && (state_r == S_RESP)) begin
      if (owner_r == OWN_IF) begin
        if_rvalid = bk_rvalid;
        if_rdata  = bk_rdata;
      end else begin
        dm_rvalid = bk_rvalid;
        dm_rdata  = bk_rdata;
      end
    end else begin
      if_rvalid = 1'b0;
      dm_rvalid = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: requester queues drive the DUT,
// a backend model answers requests, and a scoreboard compares responses.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [1:0]  dm_size;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        bk_req, bk_we, bk_ready, bk_rvalid;
  logic [1:0]  bk_size;
  logic [31:0] bk_addr, bk_wdata, bk_rdata;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .bk_req(bk_req), .bk_we(bk_we), .bk_size(bk_size), .bk_addr(bk_addr),
    .bk_wdata(bk_wdata), .bk_ready(bk_ready), .bk_rvalid(bk_rvalid), .bk_rdata(bk_rdata)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_acc = 0;

  logic [31:0] if_q[$];
  txn_t        dm_q[$];
  exp_t        if_exp[$];
  exp_t        dm_exp[$];
  txn_t        bk_exp[$];
  logic [31:0] bk_mem[logic [31:0]];

  bit if_taken = 1'b0;
  bit dm_taken = 1'b0;
  int stall_cnt = 0;
  bit hold_rsp = 1'b0;
  bit late_rv = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (bk_mem.exists(a)) return bk_mem[a];
    return 32'h0;
  endfunction

  // One clock: backend accept bookkeeping, edge, drive inputs, sample outputs.
  task automatic cycle();
    logic        acc;
    logic [31:0] acc_data;
    txn_t        e;
    exp_t        x;
    logic [31:0] junk;
    txn_t        tjunk;
    acc = bk_req && bk_ready;
    acc_data = 32'h0;
    if (acc) begin
      tests++;
      if (bk_exp.size() == 0) begin
        fails++;
        $display("FAIL bk_accept: unexpected request addr=%h, none expected", bk_addr);
      end else begin
        e = bk_exp.pop_front();
        if (bk_we !== e.we || bk_size !== e.size || bk_addr !== e.addr ||
            (e.we && bk_wdata !== e.wdata)) begin
          fails++;
          $display("FAIL bk_fields: got we=%b size=%b addr=%h wdata=%h, expected we=%b size=%b addr=%h wdata=%h",
                   bk_we, bk_size, bk_addr, bk_wdata, e.we, e.size, e.addr, e.wdata);
        end
      end
      acc_data = bk_we ? 32'h0 : mem_rd(bk_addr);
      if (bk_we) bk_mem[bk_addr] = bk_wdata;
      n_acc++;
    end
    @(posedge clock);
    #1;
    cyc++;
    if (if_taken) begin junk = if_q.pop_front(); if_taken = 1'b0; end
    if (dm_taken) begin tjunk = dm_q.pop_front(); dm_taken = 1'b0; end
    if_req  = (if_q.size() != 0);
    if_addr = if_req ? if_q[0] : 32'h0;
    dm_req  = (dm_q.size() != 0);
    if (dm_req) begin
      dm_we = dm_q[0].we; dm_size = dm_q[0].size;
      dm_addr = dm_q[0].addr; dm_wdata = dm_q[0].wdata;
    end else begin
      dm_we = 1'b0; dm_size = 2'b00; dm_addr = 32'h0; dm_wdata = 32'h0;
    end
    bk_rvalid = (acc && !hold_rsp) || late_rv;
    bk_rdata  = acc ? acc_data : (late_rv ? 32'hBAD0_BAD0 : 32'h0);
    if (bk_req) begin
      if (stall_cnt > 0) begin bk_ready = 1'b0; stall_cnt--; end
      else bk_ready = 1'b1;
    end else begin
      bk_ready = 1'b0;
    end
    #1;
    tests++;
    if (if_gnt && dm_gnt) begin
      fails++;
      $display("FAIL dual_gnt: got if_gnt=1 dm_gnt=1, expected at most one");
    end
    if (if_gnt) begin
      x.chk = 1'b1; x.data = mem_rd(if_addr);
      if_exp.push_back(x);
      e.we = 1'b0; e.size = SZ_W; e.addr = if_addr; e.wdata = 32'h0;
      bk_exp.push_back(e);
      if_taken = 1'b1;
    end
    if (dm_gnt) begin
      x.chk = !dm_we; x.data = mem_rd(dm_addr);
      dm_exp.push_back(x);
      e.we = dm_we; e.size = dm_size; e.addr = dm_addr; e.wdata = dm_wdata;
      bk_exp.push_back(e);
      dm_taken = 1'b1;
    end
    if (if_rvalid) begin
      tests++;
      if (if_exp.size() == 0) begin
        fails++;
        $display("FAIL if_rvalid: got unexpected response %h, expected none", if_rdata);
      end else begin
        x = if_exp.pop_front();
        if (if_rdata !== x.data || dm_rdata !== 32'h0 || dm_rvalid !== 1'b0) begin
          fails++;
          $display("FAIL if_resp: got rdata=%h dm_rdata=%h dm_rvalid=%b, expected %h/0/0",
                   if_rdata, dm_rdata, dm_rvalid, x.data);
        end
      end
    end
    if (dm_rvalid) begin
      tests++;
      if (dm_exp.size() == 0) begin
        fails++;
        $display("FAIL dm_rvalid: got unexpected response %h, expected none", dm_rdata);
      end else begin
        x = dm_exp.pop_front();
        if ((x.chk && dm_rdata !== x.data) || if_rdata !== 32'h0 || if_rvalid !== 1'b0) begin
          fails++;
          $display("FAIL dm_resp: got rdata=%h if_rdata=%h if_rvalid=%b, expected %h/0/0",
                   dm_rdata, if_rdata, if_rvalid, x.data);
        end
      end
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((if_q.size() != 0 || dm_q.size() != 0 || if_exp.size() != 0 || dm_exp.size() != 0)
           && n < budget) begin
      cycle();
      n++;
    end
    tests++;
    if (if_q.size() != 0 || dm_q.size() != 0 || if_exp.size() != 0 || dm_exp.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: got %0d pending after %0d cycles, expected 0",
               name, if_q.size() + dm_q.size() + if_exp.size() + dm_exp.size(), budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    tests++;
    if (bk_req !== 1'b0 || bk_we !== 1'b0 || bk_size !== 2'b00 || bk_addr !== 32'h0 ||
        bk_wdata !== 32'h0 || if_gnt !== 1'b0 || dm_gnt !== 1'b0 ||
        if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got bk_req=%b bk_we=%b bk_size=%b bk_addr=%h gnt=%b%b rvalid=%b%b, expected all 0",
               bk_req, bk_we, bk_size, bk_addr, if_gnt, dm_gnt, if_rvalid, dm_rvalid);
    end
    tests++;
    if (dut.state_r !== S_IDLE || int'(dut.starve_cnt_r) != 0 || dut.owner_r !== OWN_IF) begin
      fails++;
      $display("FAIL reset_state: got state=%0d starve=%0d owner=%0d, expected 0/0/0",
               dut.state_r, dut.starve_cnt_r, dut.owner_r);
    end
    reset = 1'b0;
  endtask

  task automatic test_if_only();
    bk_mem[32'h0100_0000] = 32'h0000_0013;
    if_q.push_back(32'h0100_0000);
    cycle();
    tests++;
    if (if_gnt !== 1'b1 || bk_req !== 1'b0) begin
      fails++;
      $display("FAIL if_only_t0: got if_gnt=%b bk_req=%b, expected 1/0", if_gnt, bk_req);
    end
    cycle();
    tests++;
    if (bk_req !== 1'b1 || bk_addr !== 32'h0100_0000 || bk_we !== 1'b0 || bk_size !== SZ_W ||
        if_gnt !== 1'b0) begin
      fails++;
      $display("FAIL if_only_t1: got bk_req=%b addr=%h we=%b size=%b, expected 1/01000000/0/10",
               bk_req, bk_addr, bk_we, bk_size);
    end
    cycle();
    tests++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h0000_0013 || bk_req !== 1'b0) begin
      fails++;
      $display("FAIL if_only_t2: got if_rvalid=%b rdata=%h bk_req=%b, expected 1/00000013/0",
               if_rvalid, if_rdata, bk_req);
    end
    drain("if_only", 10);
  endtask

  task automatic test_priority();
    txn_t t;
    int   t0, tif;
    bk_mem[32'h0100_0104] = 32'h0010_0093;
    t.we = 1'b1; t.size = SZ_W; t.addr = 32'h0100_0100; t.wdata = 32'hDEAD_BEEF;
    dm_q.push_back(t);
    if_q.push_back(32'h0100_0104);
    cycle();
    t0 = cyc;
    tests++;
    if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      fails++;
      $display("FAIL prio_first: got dm_gnt=%b if_gnt=%b, expected 1/0", dm_gnt, if_gnt);
    end
    cycle();
    tests++;
    if (bk_we !== 1'b1 || bk_addr !== 32'h0100_0100 || bk_wdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL prio_store: got we=%b addr=%h wdata=%h, expected 1/01000100/deadbeef",
               bk_we, bk_addr, bk_wdata);
    end
    tif = -1;
    for (int i = 0; i < 10 && tif < 0; i++) begin
      cycle();
      if (if_gnt) tif = cyc;
    end
    tests++;
    if (tif - t0 != 3) begin
      fails++;
      $display("FAIL prio_spacing: got if_gnt %0d cycles after dm_gnt, expected 3", tif - t0);
    end
    drain("prio", 20);
    tests++;
    if (mem_rd(32'h0100_0100) !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL prio_mem: got %h, expected deadbeef", mem_rd(32'h0100_0100));
    end
  endtask

  task automatic test_backpressure();
    txn_t t;
    bk_mem[32'h0100_0200] = 32'h1234_5678;
    stall_cnt = 5;
    t.we = 1'b0; t.size = SZ_W; t.addr = 32'h0100_0200; t.wdata = 32'h0;
    dm_q.push_back(t);
    if_q.push_back(32'h0100_0008);
    cycle();
    tests++;
    if (dm_gnt !== 1'b1) begin
      fails++;
      $display("FAIL bp_gnt: got dm_gnt=%b, expected 1", dm_gnt);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      tests++;
      if (bk_req !== 1'b1 || bk_addr !== 32'h0100_0200 || bk_we !== 1'b0 || bk_ready !== 1'b0 ||
          if_gnt !== 1'b0 || dm_gnt !== 1'b0 || dm_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d: got bk_req=%b addr=%h gnt=%b%b rvalid=%b%b, expected 1/01000200/00/00",
                 i, bk_req, bk_addr, if_gnt, dm_gnt, if_rvalid, dm_rvalid);
      end
    end
    cycle();
    tests++;
    if (bk_ready !== 1'b1 || bk_req !== 1'b1 || dm_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL bp_accept: got bk_ready=%b bk_req=%b dm_rvalid=%b, expected 1/1/0",
               bk_ready, bk_req, dm_rvalid);
    end
    cycle();
    tests++;
    if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h1234_5678) begin
      fails++;
      $display("FAIL bp_resp: got dm_rvalid=%b rdata=%h, expected 1/12345678", dm_rvalid, dm_rdata);
    end
    drain("bp", 20);
  endtask

  task automatic test_starvation();
    txn_t t;
    bit   order[$];
    int   first_if, max_st, exp_first;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      t.we = 1'b0; t.size = SZ_W; t.addr = 32'h0100_0300 + 32'(4 * i); t.wdata = 32'h0;
      bk_mem[t.addr] = 32'hC000_0000 + 32'(i);
      dm_q.push_back(t);
    end
    if_q.push_back(32'h0100_000C);
    max_st = 0;
    for (int i = 0; i < 60 && order.size() < 7; i++) begin
      cycle();
      if (dm_gnt) order.push_back(1'b0);
      if (if_gnt) order.push_back(1'b1);
      if (int'(dut.starve_cnt_r) > max_st) max_st = int'(dut.starve_cnt_r);
    end
    first_if = -1;
    for (int i = 0; i < order.size(); i++) begin
      if (order[i] && first_if < 0) first_if = i;
    end
`ifdef MEM_ARB_FAIR_EN
    exp_first = 4;
`else
    exp_first = 6;
`endif
    tests++;
    if (first_if != exp_first) begin
      fails++;
      $display("FAIL starve_order: got %0d dm grants before if grant, expected %0d", first_if, exp_first);
    end
    tests++;
    if (max_st != 4) begin
      fails++;
      $display("FAIL starve_max: got %0d, expected 4", max_st);
    end
    drain("starve", 30);
    tests++;
    if (int'(dut.starve_cnt_r) != 0) begin
      fails++;
      $display("FAIL starve_clear: got %0d, expected 0", dut.starve_cnt_r);
    end
  endtask

  task automatic test_reset_in_resp();
    txn_t t;
    int   acc0;
    bk_mem[32'h0100_0010] = 32'h1111_1111;
    hold_rsp = 1'b1;
    acc0 = n_acc;
    t.we = 1'b0; t.size = SZ_W; t.addr = 32'h0100_0010; t.wdata = 32'h0;
    dm_q.push_back(t);
    for (int i = 0; i < 20 && n_acc == acc0; i++) cycle();
    cycle();
    tests++;
    if (dut.state_r !== S_RESP || bk_req !== 1'b0) begin
      fails++;
      $display("FAIL rir_resp: got state=%0d bk_req=%b, expected 2/0", dut.state_r, bk_req);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    if_exp.delete();
    dm_exp.delete();
    bk_exp.delete();
    tests++;
    if (dut.state_r !== S_IDLE || bk_req !== 1'b0) begin
      fails++;
      $display("FAIL rir_idle: got state=%0d bk_req=%b, expected 0/0", dut.state_r, bk_req);
    end
    hold_rsp = 1'b0;
    late_rv = 1'b1;
    cycle();
    late_rv = 1'b0;
    tests++;
    if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0 || dm_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rir_late: got dm_rvalid=%b if_rvalid=%b dm_rdata=%h, expected 0/0/0",
               dm_rvalid, if_rvalid, dm_rdata);
    end
    cycle();
  endtask

  task automatic test_byte_load();
    txn_t t;
    bit   seen;
    bk_mem[32'h0100_0203] = 32'h0000_00A5;
    t.we = 1'b0; t.size = SZ_B; t.addr = 32'h0100_0203; t.wdata = 32'h0;
    dm_q.push_back(t);
    cycle();
    cycle();
    tests++;
    if (bk_req !== 1'b1 || bk_size !== SZ_B || bk_addr !== 32'h0100_0203) begin
      fails++;
      $display("FAIL byte_req: got bk_req=%b size=%b addr=%h, expected 1/00/01000203",
               bk_req, bk_size, bk_addr);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      if (dm_rvalid) begin
        seen = 1'b1;
        tests++;
        if (dm_rdata !== 32'h0000_00A5 || if_rvalid !== 1'b0) begin
          fails++;
          $display("FAIL byte_resp: got dm_rdata=%h if_rvalid=%b, expected 000000a5/0",
                   dm_rdata, if_rvalid);
        end
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL byte_timeout: got no dm_rvalid, expected one");
    end
    drain("byte", 10);
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'b00; dm_addr = 32'h0; dm_wdata = 32'h0;
    bk_ready = 1'b0; bk_rvalid = 1'b0; bk_rdata = 32'h0;
    test_reset();
    test_if_only();
    test_priority();
    test_backpressure();
    test_starvation();
    test_reset_in_resp();
    test_byte_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
